// File: rtl/hw_input_stream_packer.sv
// rtl/hw_input_stream_packer.sv - frame packer from valid/ready stream to ap_vld/ap_ack value+last pairs
module hw_input_stream_packer #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic              ap_done,
    input  logic [CNT_W-1:0]  frame_len,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] hw_input_V_value_V,
    output logic              hw_input_V_value_V_ap_vld,
    input  logic              hw_input_V_value_V_ap_ack,
    output logic              hw_input_V_last_V,
    output logic              hw_input_V_last_V_ap_vld,
    input  logic              hw_input_V_last_V_ap_ack
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0]  len;
    logic [CNT_W-1:0]  in_cnt;
    logic [CNT_W-1:0]  out_cnt;

    // Output register: payload plus one valid flag per handshake channel
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              value_vld;
    logic              last_vld;

    // Two-entry skid FIFO, each entry is {data, last}
    logic [DATA_W:0]   fifo_mem [2];
    logic              fifo_rd_ptr;
    logic              fifo_wr_ptr;
    logic [1:0]        fifo_cnt;

    logic fifo_full;
    logic fifo_empty;
    logic out_busy;
    logic retire;
    logic slot_free;
    logic accept;
    logic in_last;
    logic load_fifo;
    logic load_bypass;
    logic push;
    logic start;
    logic final_retire;

    assign fifo_full  = (fifo_cnt == 2'd2);
    assign fifo_empty = (fifo_cnt == 2'd0);
    assign out_busy   = value_vld || last_vld;
    // A beat retires once every flag still outstanding is acked this cycle
    assign retire     = out_busy
                        && (!value_vld || hw_input_V_value_V_ap_ack)
                        && (!last_vld  || hw_input_V_last_V_ap_ack);
    assign slot_free  = !out_busy || retire;

    assign s_ready    = (state == S_RUN) && !fifo_full && (in_cnt < len);
    assign accept     = s_valid && s_ready;
    assign in_last    = ((in_cnt + CNT_ONE) == len);

    // FIFO head always has priority over a new beat so ordering is preserved
    assign load_fifo   = slot_free && !fifo_empty;
    assign load_bypass = slot_free && fifo_empty && accept;
    assign push        = accept && !load_bypass;

    assign start        = (state == S_IDLE) && ap_start;
    assign final_retire = retire && ((out_cnt + CNT_ONE) == len);

    assign ap_idle  = (state == S_IDLE);
    assign ap_ready = start;
    assign ap_done  = (state == S_DONE);

    assign hw_input_V_value_V        = out_data;
    assign hw_input_V_value_V_ap_vld = value_vld;
    assign hw_input_V_last_V         = out_last;
    assign hw_input_V_last_V_ap_vld  = last_vld;

    // State register
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: DONE is entered on the edge that retires the final beat
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (ap_start) begin
                    state_nxt = (frame_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (final_retire || (out_cnt == len)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Frame counters, output register and skid FIFO
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            len         <= '0;
            in_cnt      <= '0;
            out_cnt     <= '0;
            out_data    <= '0;
            out_last    <= 1'b0;
            value_vld   <= 1'b0;
            last_vld    <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            fifo_rd_ptr <= 1'b0;
            fifo_wr_ptr <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (start) begin
                len     <= frame_len;
                in_cnt  <= '0;
                out_cnt <= '0;
            end else begin
                if (accept) begin
                    in_cnt <= in_cnt + CNT_ONE;
                end
                if (retire) begin
                    out_cnt <= out_cnt + CNT_ONE;
                end
            end

            if (load_fifo || load_bypass) begin
                value_vld <= 1'b1;
                last_vld  <= 1'b1;
                out_data  <= load_fifo ? fifo_mem[fifo_rd_ptr][DATA_W:1] : s_data;
                out_last  <= load_fifo ? fifo_mem[fifo_rd_ptr][0] : in_last;
            end else begin
                if (value_vld && hw_input_V_value_V_ap_ack) begin
                    value_vld <= 1'b0;
                end
                if (last_vld && hw_input_V_last_V_ap_ack) begin
                    last_vld <= 1'b0;
                end
            end

            if (push) begin
                fifo_mem[fifo_wr_ptr] <= {s_data, in_last};
                fifo_wr_ptr           <= ~fifo_wr_ptr;
            end
            if (load_fifo) begin
                fifo_rd_ptr <= ~fifo_rd_ptr;
            end
            case ({push, load_fifo})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_hw_input_stream_packer.sv
// tb/tb_hw_input_stream_packer.sv - randomized self-checking bench for hw_input_stream_packer
module tb_hw_input_stream_packer;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              ap_rst;
    logic              ap_start;
    logic              ap_idle;
    logic              ap_ready;
    logic              ap_done;
    logic [CNT_W-1:0]  frame_len;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] value;
    logic              value_vld;
    logic              value_ack;
    logic              last;
    logic              last_vld;
    logic              last_ack;

    always #5 clk = ~clk;

    hw_input_stream_packer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .ap_clk                    (clk),
        .ap_rst                    (ap_rst),
        .ap_start                  (ap_start),
        .ap_idle                   (ap_idle),
        .ap_ready                  (ap_ready),
        .ap_done                   (ap_done),
        .frame_len                 (frame_len),
        .s_data                    (s_data),
        .s_valid                   (s_valid),
        .s_ready                   (s_ready),
        .hw_input_V_value_V        (value),
        .hw_input_V_value_V_ap_vld (value_vld),
        .hw_input_V_value_V_ap_ack (value_ack),
        .hw_input_V_last_V         (last),
        .hw_input_V_last_V_ap_vld  (last_vld),
        .hw_input_V_last_V_ap_ack  (last_ack)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        bit                v_taken;
        bit                l_taken;
    } beat_t;

    beat_t             q[$];
    logic [DATA_W-1:0] data_q[$];
    logic [DATA_W-1:0] exp_vals[$];
    logic [DATA_W-1:0] obs_vals[$];
    logic              obs_lasts[$];
    int                obs_acc;
    int                obs_done;

    int checks = 0;
    int errors = 0;
    int phase;
    int cur_len;
    int acc_cnt;
    int ret_cnt;
    int valid_mode;
    int vack_mode;
    int lack_mode;
    bit start_noise;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic pick(input int mode, input logic cur);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return logic'($urandom_range(0, 1));
            default: return cur;
        endcase
    endfunction

    task automatic drive(input bit start);
        if (valid_mode == 1)      s_valid = (data_q.size() > 0);
        else if (valid_mode == 2) s_valid = (data_q.size() > 0) && ($urandom_range(0, 1) == 1);
        else                      s_valid = 1'b0;
        s_data    = (data_q.size() > 0) ? data_q[0] : $urandom;
        value_ack = pick(vack_mode, value_ack);
        last_ack  = pick(lack_mode, last_ack);
        if (start)                            ap_start = 1'b1;
        else if (start_noise && (phase != 0)) ap_start = logic'($urandom_range(0, 1));
        else                                  ap_start = 1'b0;
    endtask

    // Reference: in-order beats, each delivered once per channel, at most 3 in flight
    task automatic observe();
        bit    exp_vv, exp_lv, exp_sr, v_hs, l_hs, acc;
        beat_t b;
        chk("ap_idle", ap_idle, phase == 0);
        chk("ap_ready", ap_ready, (phase == 0) && ap_start);
        chk("ap_done", ap_done, phase == 2);
        exp_sr = (phase == 1) && (q.size() < 3) && (acc_cnt < cur_len);
        chk("s_ready", s_ready, exp_sr);
        exp_vv = (q.size() > 0) && !q[0].v_taken;
        exp_lv = (q.size() > 0) && !q[0].l_taken;
        chk("value_vld", value_vld, exp_vv);
        chk("last_vld", last_vld, exp_lv);
        if (exp_vv) chk("value", value, q[0].data);
        if (exp_lv) chk("last", last, q[0].last);

        if (value_vld && value_ack) obs_vals.push_back(value);
        if (last_vld && last_ack)   obs_lasts.push_back(last);
        if (s_valid && s_ready)     obs_acc++;
        if (ap_done)                obs_done++;

        v_hs = exp_vv && value_ack;
        l_hs = exp_lv && last_ack;
        acc  = exp_sr && s_valid;
        if (phase == 0) begin
            if (ap_start) begin
                cur_len = int'(frame_len);
                acc_cnt = 0;
                ret_cnt = 0;
                phase   = (frame_len == 0) ? 2 : 1;
            end
        end else if (phase == 2) begin
            phase = 0;
        end else begin
            if (v_hs) q[0].v_taken = 1'b1;
            if (l_hs) q[0].l_taken = 1'b1;
            if ((q.size() > 0) && q[0].v_taken && q[0].l_taken) begin
                void'(q.pop_front());
                ret_cnt++;
                if (ret_cnt == cur_len) phase = 2;
            end
            if (acc) begin
                b.data    = s_data;
                b.last    = (acc_cnt == cur_len - 1);
                b.v_taken = 1'b0;
                b.l_taken = 1'b0;
                q.push_back(b);
                acc_cnt++;
                void'(data_q.pop_front());
            end
        end
    endtask

    task automatic tick(input bit start);
        drive(start);
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int len);
        frame_len = CNT_W'(len);
        obs_vals.delete();
        obs_lasts.delete();
        obs_acc  = 0;
        obs_done = 0;
        exp_vals = data_q;
        tick(1'b1);
    endtask

    task automatic run_until_idle(input int bound);
        int n = 0;
        while ((phase != 0) && (n < bound)) begin
            tick(1'b0);
            n++;
        end
        chk("frame_timeout", phase, 0);
    endtask

    task automatic check_frame(input string tag);
        int n = exp_vals.size();
        chk({tag, "_nvals"}, obs_vals.size(), n);
        chk({tag, "_nlasts"}, obs_lasts.size(), n);
        for (int i = 0; i < n && i < obs_vals.size(); i++)  chk({tag, "_val"}, obs_vals[i], exp_vals[i]);
        for (int i = 0; i < n && i < obs_lasts.size(); i++) chk({tag, "_tag"}, obs_lasts[i], i == n - 1);
        chk({tag, "_done_pulses"}, obs_done, 1);
    endtask

    task automatic fill(input int n);
        data_q.delete();
        for (int i = 0; i < n; i++) data_q.push_back($urandom);
    endtask

    initial begin
        ap_rst = 1'b1; ap_start = 1'b0; frame_len = '0; s_data = '0; s_valid = 1'b0;
        value_ack = 1'b0; last_ack = 1'b0;
        phase = 0; cur_len = 0; acc_cnt = 0; ret_cnt = 0;
        valid_mode = 0; vack_mode = 0; lack_mode = 0; start_noise = 1'b0;
        obs_acc = 0; obs_done = 0;

        // Reset held three cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_idle", ap_idle, 1'b1);
        chk("rst_ready", ap_ready, 1'b0);
        chk("rst_done", ap_done, 1'b0);
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_value_vld", value_vld, 1'b0);
        chk("rst_last_vld", last_vld, 1'b0);
        chk("rst_value", value, 0);
        chk("rst_last", last, 1'b0);
        ap_rst = 1'b0;
        repeat (3) tick(1'b0);

        // Streaming 5,6,7,8 with both acks high
        valid_mode = 1; vack_mode = 1; lack_mode = 1;
        data_q = '{32'd5, 32'd6, 32'd7, 32'd8};
        start_frame(4);
        run_until_idle(30);
        check_frame("stream");
        tick(1'b0);

        // Split acks: value acked at t, last acked at t+3
        vack_mode = 3; lack_mode = 3; value_ack = 1'b0; last_ack = 1'b0;
        data_q = '{32'hA1, 32'hA2};
        start_frame(2);
        tick(1'b0);
        value_ack = 1'b1; tick(1'b0);
        value_ack = 1'b0; tick(1'b0);
        tick(1'b0);
        last_ack = 1'b1;  tick(1'b0);
        last_ack = 1'b0;  tick(1'b0);
        chk("split_next_vld", value_vld, 1'b1);
        chk("split_next_val", value, 32'hA2);
        vack_mode = 1; lack_mode = 1;
        run_until_idle(30);
        check_frame("split");

        // Backpressure: acks low for 10 cycles with an 8-beat frame
        vack_mode = 0; lack_mode = 0;
        fill(8);
        start_frame(8);
        repeat (10) tick(1'b0);
        chk("bp_accepted", obs_acc, 3);
        chk("bp_s_ready", s_ready, 1'b0);
        vack_mode = 1; lack_mode = 1;
        run_until_idle(60);
        check_frame("bp");

        // Zero-length frame
        data_q.delete();
        start_frame(0);
        run_until_idle(10);
        chk("len0_done_pulses", obs_done, 1);
        chk("len0_vals", obs_vals.size(), 0);

        // Asynchronous reset after two beats retired
        fill(4);
        start_frame(4);
        for (int n = 0; n < 20 && obs_vals.size() < 2; n++) tick(1'b0);
        chk("pre_rst_retired", obs_vals.size(), 2);
        chk("pre_rst_vld", value_vld, 1'b1);
        #2;
        ap_rst = 1'b1;
        #1;
        chk("arst_value_vld", value_vld, 1'b0);
        chk("arst_last_vld", last_vld, 1'b0);
        chk("arst_idle", ap_idle, 1'b1);
        chk("arst_s_ready", s_ready, 1'b0);
        phase = 0; q.delete(); data_q.delete(); cur_len = 0; acc_cnt = 0;
        @(posedge clk);
        #1;
        ap_rst = 1'b0;
        tick(1'b0);
        fill(3);
        start_frame(3);
        run_until_idle(30);
        check_frame("post_rst");

        // Random frames with random valid, random acks and stray ap_start
        valid_mode = 2; vack_mode = 2; lack_mode = 2; start_noise = 1'b1;
        for (int f = 0; f < 8; f++) begin
            fill($urandom_range(1, 12));
            start_frame(data_q.size());
            run_until_idle(600);
            check_frame("rand");
        end
        start_noise = 1'b0;
        repeat (2) tick(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hw_input_stream_packer.md
# hw_input_stream_packer

Upstream feeder for the HLS accelerator top's `hw_input_V` port pair. It takes a plain valid/ready pixel stream and emits it as per-beat `value`/`last` pairs, each on its own ap_vld/ap_ack handshake. It tags the final beat of each frame with `last=1` and runs one frame per `ap_start`, reporting status through ap_ctrl_hs-style `ap_idle`/`ap_ready`/`ap_done`.

## Interface
- `DATA_W`, default 32: pixel/value width.
- `CNT_W`, default 16: frame-length and beat-counter width.

- `ap_clk` in 1: clock; all state on the rising edge.
- `ap_rst` in 1: reset, asynchronous, active-high.
- `ap_start` in 1: start one frame; honoured only in IDLE.
- `ap_idle` out 1: high in IDLE.
- `ap_ready` out 1: one-cycle pulse in the cycle `ap_start` is accepted and `frame_len` is sampled.
- `ap_done` out 1: one-cycle pulse when the frame's final beat retires.
- `frame_len` in CNT_W: beats per frame, sampled at start.
- `s_data` in DATA_W: upstream pixel.
- `s_valid` in 1: upstream valid.
- `s_ready` out 1: upstream ready.
- `hw_input_V_value_V` out DATA_W: value payload.
- `hw_input_V_value_V_ap_vld` out 1: value valid.
- `hw_input_V_value_V_ap_ack` in 1: value acknowledge.
- `hw_input_V_last_V` out 1: end-of-frame flag.
- `hw_input_V_last_V_ap_vld` out 1: last valid.
- `hw_input_V_last_V_ap_ack` in 1: last acknowledge.

## Operation
- FSM states:
  - IDLE: `ap_start` samples `frame_len` into `len`, clears counters, pulses `ap_ready`, then goes to RUN. If `len==0`, goes to DONE instead.
  - RUN: accepts and emits beats. When `out_cnt==len`, goes to DONE.
  - DONE: one cycle; `ap_done=1`; next state IDLE.
- Input acceptance:
  - `s_ready = RUN && !fifo_full && in_cnt<len`, where `fifo_full` means both skid-FIFO entries are occupied.
  - A beat is accepted when `s_valid && s_ready`.
  - Each accepted beat is stored as `{data, last=(in_cnt==len-1)}` and increments `in_cnt`.
- Storage is an output register plus a 2-entry skid FIFO: 3 beats maximum in flight. An accepted beat goes straight to the output register if it is empty or retiring that cycle; otherwise it goes to the FIFO.
- Output register behaviour:
  - Loading a beat sets both `value_vld` and `last_vld`.
  - Each flag clears independently on its own `vld&&ack`.
  - Ack while the matching vld is low is ignored.
  - A beat retires in the cycle its final outstanding flag is acked; both flags may be acked in the same cycle.
  - Retiring increments `out_cnt`, and the next beat, from the FIFO head or a bypass, loads in the same edge with no bubble.
  - Payload is held stable while either flag is high.
- `ap_start` outside IDLE is ignored.
- Counters are CNT_W bits. `in_cnt` and `out_cnt` never exceed `len`, so there is no wrap.

## Timing
- Reset values: `ap_idle=1`; all other outputs 0 (`s_ready`, `ap_ready`, `ap_done`, both vlds, both payloads). Counters and FIFO are empty.
- Assertion of `ap_rst` mid-frame clears outputs immediately, asynchronously; the partial frame is discarded.
- Start: `ap_start` sampled at edge E. RUN from E+1, so `s_ready` can first be high in the cycle after E.
- Latency: beat accepted at edge k shows both vlds high from k until the retiring edge (vld valid after edge k). Minimum in-to-out latency is 1 cycle.
- Throughput is 1 beat/cycle with both acks held high.
- `ap_done` is high for exactly the cycle after the final retiring edge. `ap_idle` rises on the following edge.
- `len==0`: DONE in the cycle after start; no vld is ever raised.
- Simultaneous events: retire plus accept in the same cycle with the FIFO full → `s_ready` was already low, so nothing is lost. Retire while the FIFO is empty and a bypass beat is present → the bypass beat loads directly.

## Test plan
- Reset: hold `ap_rst` 3 cycles → `ap_idle=1`, all other outputs 0. Release → state unchanged until `ap_start`.
- Streaming: `frame_len=4`, `s_data` 5,6,7,8 continuous, both acks tied 1 → value 5,6,7,8 on 4 consecutive cycles; last 0,0,0,1; a single `ap_done` pulse 1 cycle after the final retire; then `ap_idle=1`.
- Split acks: value ack at cycle t, last ack at t+3 → `value_vld` low from t+1; `last_vld` high through t+3; next beat loads at t+4; no duplicated or skipped value.
- Backpressure: both acks 0 for 10 cycles, `s_valid` high, `frame_len=8` → exactly 3 beats accepted, then `s_ready=0`. Releasing the acks drains all 8 beats in order with the last tag on beat 8.
- `frame_len=0` → `ap_ready` pulse, `ap_done` pulse the next cycle, vlds never high.
- Async reset mid-frame after 2 of 4 beats retired → vlds fall without a clock edge and `ap_idle=1`. A new frame with `frame_len=3` then emits 3 beats with last on beat 3 and `ap_done` once.
